// File: rtl/id_decode_dispatch_if.sv
// ----------------------------------------------------------------------------
// id_decode_dispatch_if
//   Bundles the ID-stage dispatch traffic into one interface:
//     - instruction side: in_valid/in_ready handshake plus the per-channel
//       sub-decoder result vectors (src_*), packed channel 0 in the LSBs.
//       Two-port fields pack as {port2, port1}.
//     - EX side: out_valid/out_ready handshake plus the head-entry bundle
//       (operand_1/2, write_reg_en, write_reg_addr).
//   modport slave  : the dispatch block itself
//   modport master : the surrounding IF/decoder/EX environment
// ----------------------------------------------------------------------------
interface id_decode_dispatch_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_SRC-1:0]              src_hit;
    logic [NUM_SRC*2-1:0]            src_rd_en;
    logic [NUM_SRC*2*REG_ADDR_W-1:0] src_rd_addr;
    logic [NUM_SRC*2*DATA_W-1:0]     src_operand;
    logic [NUM_SRC-1:0]              src_wr_en;
    logic [NUM_SRC*REG_ADDR_W-1:0]   src_wr_addr;
    logic [NUM_SRC-1:0]              src_is_load;
    logic [NUM_SRC-1:0]              src_br_taken;
    logic [NUM_SRC*ADDR_W-1:0]       src_br_addr;
    logic                            out_valid;
    logic                            out_ready;
    logic [DATA_W-1:0]               operand_1;
    logic [DATA_W-1:0]               operand_2;
    logic                            write_reg_en;
    logic [REG_ADDR_W-1:0]           write_reg_addr;

    modport slave (
        input  in_valid, src_hit, src_rd_en, src_rd_addr, src_operand,
               src_wr_en, src_wr_addr, src_is_load, src_br_taken, src_br_addr,
               out_ready,
        output in_ready, out_valid, operand_1, operand_2, write_reg_en, write_reg_addr
    );

    modport master (
        output in_valid, src_hit, src_rd_en, src_rd_addr, src_operand,
               src_wr_en, src_wr_addr, src_is_load, src_br_taken, src_br_addr,
               out_ready,
        input  in_ready, out_valid, operand_1, operand_2, write_reg_en, write_reg_addr
    );
endinterface

// File: rtl/id_decode_dispatch.sv
// ----------------------------------------------------------------------------
// id_decode_dispatch
//   ID-stage dispatch: picks the highest-priority (lowest index) claiming
//   sub-decoder channel, drives its register read ports, holds back one
//   cycle on a load-use hazard, and pushes the selected bundle into a
//   DEPTH-entry FIFO feeding EX. Taken branches raise a one-cycle redirect
//   pulse when the instruction is accepted.
// Ports
//   i_clk, i_rst_n        clock / asynchronous active-low reset
//   bus (slave)           instruction handshake + src_* channels in,
//                         EX handshake + head bundle out
//   o_reg_read_en_1/2     selected read enables (combinational)
//   o_reg_addr_1/2        selected read addresses (combinational)
//   o_branch_flag/addr    registered redirect pulse and target
//   o_illegal_inst        pulse after accepting a zero-hit instruction
//   o_multi_hit_err       sticky flag: accepted instruction with >1 hit
//   o_stall_cnt           saturating load-use bubble counter
// ----------------------------------------------------------------------------
module id_decode_dispatch #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    id_decode_dispatch_if.slave   bus,
    output logic                  o_reg_read_en_1,
    output logic                  o_reg_read_en_2,
    output logic [REG_ADDR_W-1:0] o_reg_addr_1,
    output logic [REG_ADDR_W-1:0] o_reg_addr_2,
    output logic                  o_branch_flag,
    output logic [ADDR_W-1:0]     o_branch_addr,
    output logic                  o_illegal_inst,
    output logic                  o_multi_hit_err,
    output logic [15:0]           o_stall_cnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic                  w_rd_en1_p0, w_rd_en2_p0, w_wr_en_p0, w_is_load_p0, w_br_taken_p0;
    logic [REG_ADDR_W-1:0] w_rd_addr1_p0, w_rd_addr2_p0, w_wr_addr_p0;
    logic [DATA_W-1:0]     w_op1_p0, w_op2_p0;
    logic [ADDR_W-1:0]     w_br_addr_p0;
    logic                  w_any_hit_p0, w_multi_hit_p0, w_hazard_p0, w_in_ready_p0, w_push_p0;
    logic                  w_pop_p1, w_vld_p1;

    logic [DATA_W-1:0]     r_q_op1_p1   [DEPTH];
    logic [DATA_W-1:0]     r_q_op2_p1   [DEPTH];
    logic                  r_q_wen_p1   [DEPTH];
    logic [REG_ADDR_W-1:0] r_q_waddr_p1 [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_ld_v;
    logic [REG_ADDR_W-1:0] r_ld_addr;
    logic                  r_branch_flag, r_illegal, r_multi;
    logic [ADDR_W-1:0]     r_branch_addr;
    logic [15:0]           r_stall;

    // ---- p0: priority select + hazard detect ----
    // Descending scan so the lowest-index claiming channel is written last and wins.
    always_comb begin
        w_rd_en1_p0   = 1'b0;
        w_rd_en2_p0   = 1'b0;
        w_rd_addr1_p0 = '0;
        w_rd_addr2_p0 = '0;
        w_op1_p0      = '0;
        w_op2_p0      = '0;
        w_wr_en_p0    = 1'b0;
        w_wr_addr_p0  = '0;
        w_is_load_p0  = 1'b0;
        w_br_taken_p0 = 1'b0;
        w_br_addr_p0  = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (bus.src_hit[k]) begin
                w_rd_en1_p0   = bus.src_rd_en[2*k];
                w_rd_en2_p0   = bus.src_rd_en[2*k+1];
                w_rd_addr1_p0 = bus.src_rd_addr[(2*k)*REG_ADDR_W +: REG_ADDR_W];
                w_rd_addr2_p0 = bus.src_rd_addr[(2*k+1)*REG_ADDR_W +: REG_ADDR_W];
                w_op1_p0      = bus.src_operand[(2*k)*DATA_W +: DATA_W];
                w_op2_p0      = bus.src_operand[(2*k+1)*DATA_W +: DATA_W];
                w_wr_en_p0    = bus.src_wr_en[k];
                w_wr_addr_p0  = bus.src_wr_addr[k*REG_ADDR_W +: REG_ADDR_W];
                w_is_load_p0  = bus.src_is_load[k];
                w_br_taken_p0 = bus.src_br_taken[k];
                w_br_addr_p0  = bus.src_br_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_any_hit_p0   = |bus.src_hit;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign w_multi_hit_p0 = |(bus.src_hit & (bus.src_hit - NUM_SRC'(1)));

    // $0 is hardwired, so a load targeting it can never create a dependency.
    assign w_hazard_p0 = r_ld_v && (r_ld_addr != '0) &&
                         ((w_rd_en1_p0 && (w_rd_addr1_p0 == r_ld_addr)) ||
                          (w_rd_en2_p0 && (w_rd_addr2_p0 == r_ld_addr)));

    assign w_vld_p1      = (r_count != '0);
    assign w_pop_p1      = w_vld_p1 && bus.out_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign w_in_ready_p0 = !w_hazard_p0 && ((r_count < CNT_W'(DEPTH)) || w_pop_p1);
    assign w_push_p0     = bus.in_valid && w_in_ready_p0;

    assign bus.in_ready    = w_in_ready_p0;
    assign o_reg_read_en_1 = w_rd_en1_p0;
    assign o_reg_read_en_2 = w_rd_en2_p0;
    assign o_reg_addr_1    = w_rd_addr1_p0;
    assign o_reg_addr_2    = w_rd_addr2_p0;

    // ---- p1: dispatch queue storage ----
    always_ff @(posedge i_clk) begin
        if (w_push_p0) begin
            r_q_op1_p1[r_wr_ptr]   <= w_op1_p0;
            r_q_op2_p1[r_wr_ptr]   <= w_op2_p0;
            r_q_wen_p1[r_wr_ptr]   <= w_wr_en_p0;
            r_q_waddr_p1[r_wr_ptr] <= w_wr_addr_p0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_ld_v        <= 1'b0;
            r_ld_addr     <= '0;
            r_branch_flag <= 1'b0;
            r_branch_addr <= '0;
            r_illegal     <= 1'b0;
            r_multi       <= 1'b0;
            r_stall       <= '0;
        end else begin
            if (w_push_p0) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop_p1)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push_p0 && !w_pop_p1)      r_count <= r_count + CNT_W'(1);
            else if (!w_push_p0 && w_pop_p1) r_count <= r_count - CNT_W'(1);

            // Tracker: a stalled cycle retires the load, giving exactly one bubble.
            if (w_push_p0) begin
                r_ld_v    <= w_is_load_p0 && w_wr_en_p0;
                r_ld_addr <= w_wr_addr_p0;
            end else if (w_hazard_p0) begin
                r_ld_v    <= 1'b0;
            end

            r_branch_flag <= w_push_p0 && w_br_taken_p0;
            if (w_push_p0 && w_br_taken_p0) r_branch_addr <= w_br_addr_p0;
            r_illegal <= w_push_p0 && !w_any_hit_p0;
            if (w_push_p0 && w_multi_hit_p0) r_multi <= 1'b1;
            if (w_hazard_p0) r_stall <= sat_inc16(r_stall);
        end
    end

    // Head fields read as zero whenever the queue is empty.
    assign bus.out_valid      = w_vld_p1;
    assign bus.operand_1      = w_vld_p1 ? r_q_op1_p1[r_rd_ptr]   : '0;
    assign bus.operand_2      = w_vld_p1 ? r_q_op2_p1[r_rd_ptr]   : '0;
    assign bus.write_reg_en   = w_vld_p1 ? r_q_wen_p1[r_rd_ptr]   : 1'b0;
    assign bus.write_reg_addr = w_vld_p1 ? r_q_waddr_p1[r_rd_ptr] : '0;

    assign o_branch_flag   = r_branch_flag;
    assign o_branch_addr   = r_branch_addr;
    assign o_illegal_inst  = r_illegal;
    assign o_multi_hit_err = r_multi;
    assign o_stall_cnt     = r_stall;
endmodule

// File: tb/tb_id_decode_dispatch.sv
module tb_id_decode_dispatch;
    localparam int NS    = 4;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int RA    = 5;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          o_en1, o_en2, o_br, o_ill, o_multi;
    logic [RA-1:0] o_a1, o_a2;
    logic [AW-1:0] o_bra;
    logic [15:0]   o_stall;

    id_decode_dispatch_if #(.NUM_SRC(NS), .DATA_W(DW), .ADDR_W(AW), .REG_ADDR_W(RA)) bus();

    id_decode_dispatch #(.NUM_SRC(NS), .DATA_W(DW), .ADDR_W(AW), .REG_ADDR_W(RA), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave),
        .o_reg_read_en_1(o_en1), .o_reg_read_en_2(o_en2),
        .o_reg_addr_1(o_a1), .o_reg_addr_2(o_a2),
        .o_branch_flag(o_br), .o_branch_addr(o_bra),
        .o_illegal_inst(o_ill), .o_multi_hit_err(o_multi), .o_stall_cnt(o_stall)
    );

    typedef struct {
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic          wen;
        logic [RA-1:0] waddr;
    } entry_t;

    // Reference model state
    entry_t        mq[$];
    logic          m_ld_v, m_br, m_ill, m_multi;
    logic [RA-1:0] m_ld_addr;
    logic [AW-1:0] m_bra;
    logic [15:0]   m_stall;

    // Per-cycle expectations and sampled combinational outputs
    int            e_sel, e_nhit;
    logic          e_rdy, e_en1, e_en2, e_haz, e_acc, e_pop, e_load, e_brt;
    logic [RA-1:0] e_a1, e_a2;
    logic [AW-1:0] e_brtgt;
    entry_t        e_ent, e_head;
    logic          s_rdy, s_en1, s_en2;
    logic [RA-1:0] s_a1, s_a2;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic clear_inputs();
        bus.in_valid     = 1'b0;
        bus.src_hit      = '0;
        bus.src_rd_en    = '0;
        bus.src_rd_addr  = '0;
        bus.src_operand  = '0;
        bus.src_wr_en    = '0;
        bus.src_wr_addr  = '0;
        bus.src_is_load  = '0;
        bus.src_br_taken = '0;
        bus.src_br_addr  = '0;
    endtask

    task automatic set_ch(input int k, input logic [1:0] en, input logic [RA-1:0] a1, input logic [RA-1:0] a2,
                          input logic [DW-1:0] op1, input logic [DW-1:0] op2, input logic wen,
                          input logic [RA-1:0] wa, input logic ld, input logic br, input logic [AW-1:0] bt);
        bus.src_hit[k]                     = 1'b1;
        bus.src_rd_en[2*k +: 2]            = en;
        bus.src_rd_addr[(2*k)*RA +: RA]    = a1;
        bus.src_rd_addr[(2*k+1)*RA +: RA]  = a2;
        bus.src_operand[(2*k)*DW +: DW]    = op1;
        bus.src_operand[(2*k+1)*DW +: DW]  = op2;
        bus.src_wr_en[k]                   = wen;
        bus.src_wr_addr[k*RA +: RA]        = wa;
        bus.src_is_load[k]                 = ld;
        bus.src_br_taken[k]                = br;
        bus.src_br_addr[k*AW +: AW]        = bt;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ld_v = 1'b0; m_ld_addr = '0; m_br = 1'b0; m_bra = '0;
        m_ill = 1'b0; m_multi = 1'b0; m_stall = '0;
    endtask

    // Evaluate the dispatch rules for the inputs currently applied.
    task automatic model_eval();
        e_sel = -1; e_nhit = 0;
        for (int k = 0; k < NS; k++) begin
            if (bus.src_hit[k]) begin
                e_nhit++;
                if (e_sel < 0) e_sel = k;
            end
        end
        e_en1 = 0; e_en2 = 0; e_a1 = '0; e_a2 = '0; e_load = 0; e_brt = 0; e_brtgt = '0;
        e_ent.op1 = '0; e_ent.op2 = '0; e_ent.wen = 1'b0; e_ent.waddr = '0;
        if (e_sel >= 0) begin
            e_en1       = bus.src_rd_en[2*e_sel];
            e_en2       = bus.src_rd_en[2*e_sel+1];
            e_a1        = bus.src_rd_addr[(2*e_sel)*RA +: RA];
            e_a2        = bus.src_rd_addr[(2*e_sel+1)*RA +: RA];
            e_ent.op1   = bus.src_operand[(2*e_sel)*DW +: DW];
            e_ent.op2   = bus.src_operand[(2*e_sel+1)*DW +: DW];
            e_ent.wen   = bus.src_wr_en[e_sel];
            e_ent.waddr = bus.src_wr_addr[e_sel*RA +: RA];
            e_load      = bus.src_is_load[e_sel];
            e_brt       = bus.src_br_taken[e_sel];
            e_brtgt     = bus.src_br_addr[e_sel*AW +: AW];
        end
        e_haz = m_ld_v && (m_ld_addr != 0) && ((e_en1 && e_a1 == m_ld_addr) || (e_en2 && e_a2 == m_ld_addr));
        e_pop = (mq.size() > 0) && bus.out_ready;
        e_rdy = !e_haz && ((mq.size() < DEPTH) || e_pop);
        e_acc = bus.in_valid && e_rdy;
    endtask

    task automatic model_commit();
        if (e_pop) void'(mq.pop_front());
        if (e_acc) mq.push_back(e_ent);
        m_br = e_acc && e_brt;
        if (e_acc && e_brt) m_bra = e_brtgt;
        m_ill = e_acc && (e_sel < 0);
        if (e_acc && e_nhit > 1) m_multi = 1'b1;
        if (e_haz && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (e_acc) begin
            m_ld_v = e_load && e_ent.wen;
            m_ld_addr = e_ent.waddr;
        end else if (e_haz) begin
            m_ld_v = 1'b0;
        end
        e_head.op1 = '0; e_head.op2 = '0; e_head.wen = 1'b0; e_head.waddr = '0;
        if (mq.size() > 0) e_head = mq[0];
    endtask

    // One clock: sample combinational outputs mid-cycle, then advance past the edge.
    task automatic step();
        @(negedge clk);
        model_eval();
        s_rdy = bus.in_ready; s_en1 = o_en1; s_en2 = o_en2; s_a1 = o_a1; s_a2 = o_a2;
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drain();
        clear_inputs();
        bus.out_ready = 1'b1;
        repeat (DEPTH + 1) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        bus.out_ready = 1'b0;
        model_reset();
        #12;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.operand_1 !== '0) begin n_fail++; $display("FAIL rst_operand_1: got %h expected 0", bus.operand_1); end
        n_cmp++; if (bus.operand_2 !== '0) begin n_fail++; $display("FAIL rst_operand_2: got %h expected 0", bus.operand_2); end
        n_cmp++; if ({bus.write_reg_en, bus.write_reg_addr} !== '0) begin n_fail++; $display("FAIL rst_write_reg: got %b/%h expected 0/0", bus.write_reg_en, bus.write_reg_addr); end
        n_cmp++; if ({o_br, o_bra} !== '0) begin n_fail++; $display("FAIL rst_branch: got %b/%h expected 0/0", o_br, o_bra); end
        n_cmp++; if ({o_ill, o_multi, o_stall} !== '0) begin n_fail++; $display("FAIL rst_status: got ill=%b multi=%b stall=%0d expected 0", o_ill, o_multi, o_stall); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_priority();
        clear_inputs();
        bus.out_ready = 1'b1;
        set_ch(1, 2'b00, 5'd0, 5'd0, 32'h11, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, '0);
        set_ch(2, 2'b00, 5'd0, 5'd0, 32'h22, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, '0);
        bus.in_valid = 1'b1;
        step();
        n_cmp++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL prio_in_ready: got %b expected 1", s_rdy); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL prio_out_valid: got %b expected 1", bus.out_valid); end
        n_cmp++; if (bus.operand_1 !== 32'h11) begin n_fail++; $display("FAIL prio_operand_1: got %h expected 00000011", bus.operand_1); end
        n_cmp++; if (o_multi !== 1'b1) begin n_fail++; $display("FAIL prio_multi_hit: got %b expected 1", o_multi); end
        clear_inputs();
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL prio_drained: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_illegal();
        clear_inputs();
        bus.out_ready = 1'b1;
        bus.src_operand = {8{32'hDEAD0000}};
        bus.src_wr_en = '1;
        bus.in_valid = 1'b1;
        step();
        n_cmp++; if (o_ill !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse: got %b expected 1", o_ill); end
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.operand_1 !== '0 || bus.write_reg_en !== 1'b0) begin
            n_fail++; $display("FAIL illegal_nop: got v=%b op1=%h wen=%b expected 1/0/0", bus.out_valid, bus.operand_1, bus.write_reg_en); end
        clear_inputs();
        step();
        n_cmp++; if (o_ill !== 1'b0) begin n_fail++; $display("FAIL illegal_one_cycle: got %b expected 0", o_ill); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        bus.out_ready = 1'b1;
        set_ch(3, 2'b00, 5'd0, 5'd0, 32'h33, 32'h0, 1'b1, 5'd5, 1'b1, 1'b0, '0);
        bus.in_valid = 1'b1;
        step();
        n_cmp++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL lu_load_accept: got %b expected 1", s_rdy); end
        clear_inputs();
        set_ch(0, 2'b01, 5'd5, 5'd0, 32'h44, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, '0);
        bus.in_valid = 1'b1;
        step();
        n_cmp++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got in_ready=%b expected 0", s_rdy); end
        n_cmp++; if (s_en1 !== 1'b1 || s_a1 !== 5'd5) begin n_fail++; $display("FAIL lu_read_port: got en=%b addr=%0d expected 1/5", s_en1, s_a1); end
        n_cmp++; if (o_stall !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d expected 1", o_stall); end
        step();
        n_cmp++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL lu_after_bubble: got in_ready=%b expected 1", s_rdy); end
        n_cmp++; if (bus.operand_1 !== 32'h44 || o_stall !== 16'd1) begin n_fail++; $display("FAIL lu_dispatch: got op1=%h stall=%0d expected 44/1", bus.operand_1, o_stall); end
        clear_inputs();
        step();
    endtask

    task automatic test_zero_load();
        clear_inputs();
        bus.out_ready = 1'b1;
        set_ch(2, 2'b00, 5'd0, 5'd0, 32'h55, 32'h0, 1'b1, 5'd0, 1'b1, 1'b0, '0);
        bus.in_valid = 1'b1;
        step();
        clear_inputs();
        set_ch(0, 2'b11, 5'd0, 5'd0, 32'h66, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, '0);
        bus.in_valid = 1'b1;
        step();
        n_cmp++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL zero_no_bubble: got in_ready=%b expected 1", s_rdy); end
        n_cmp++; if (o_stall !== 16'd1) begin n_fail++; $display("FAIL zero_stall_cnt: got %0d expected 1", o_stall); end
        clear_inputs();
        step();
    endtask

    task automatic test_backpressure();
        drain();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            set_ch(0, 2'b00, 5'd0, 5'd0, 32'hA0 + 32'(i), 32'hB0 + 32'(i), 1'b1, RA'(i + 1), 1'b0, 1'b0, '0);
            bus.in_valid = 1'b1;
            step();
            n_cmp++; if (s_rdy !== (i < 2)) begin n_fail++; $display("FAIL bp_in_ready_%0d: got %b expected %b", i, s_rdy, (i < 2)); end
            n_cmp++; if (bus.operand_1 !== 32'hA0) begin n_fail++; $display("FAIL bp_head_hold_%0d: got %h expected 000000a0", i, bus.operand_1); end
        end
        bus.out_ready = 1'b1;
        step();
        n_cmp++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_push_pop: got in_ready=%b expected 1", s_rdy); end
        n_cmp++; if (bus.operand_1 !== 32'hA1 || bus.operand_2 !== 32'hB1 || bus.write_reg_addr !== 5'd2) begin
            n_fail++; $display("FAIL bp_second: got %h/%h/%0d expected a1/b1/2", bus.operand_1, bus.operand_2, bus.write_reg_addr); end
        clear_inputs();
        step();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.operand_1 !== 32'hA2) begin n_fail++; $display("FAIL bp_third: got v=%b op1=%h expected 1/a2", bus.out_valid, bus.operand_1); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_branch();
        drain();
        set_ch(1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 32'hBFC00100);
        bus.in_valid = 1'b1;
        step();
        n_cmp++; if (o_br !== 1'b1 || o_bra !== 32'hBFC00100) begin n_fail++; $display("FAIL br_pulse: got %b/%h expected 1/bfc00100", o_br, o_bra); end
        clear_inputs();
        step();
        n_cmp++; if (o_br !== 1'b0 || o_bra !== 32'hBFC00100) begin n_fail++; $display("FAIL br_hold: got %b/%h expected 0/bfc00100", o_br, o_bra); end
        set_ch(0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 1'b1, 1'b0, '0);
        bus.in_valid = 1'b1;
        step();
        clear_inputs();
        set_ch(0, 2'b01, 5'd7, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h80000040);
        bus.in_valid = 1'b1;
        step();
        n_cmp++; if (s_rdy !== 1'b0 || o_br !== 1'b0 || o_bra !== 32'hBFC00100) begin
            n_fail++; $display("FAIL br_stalled: got rdy=%b br=%b addr=%h expected 0/0/bfc00100", s_rdy, o_br, o_bra); end
        step();
        n_cmp++; if (o_br !== 1'b1 || o_bra !== 32'h80000040) begin n_fail++; $display("FAIL br_after_stall: got %b/%h expected 1/80000040", o_br, o_bra); end
        clear_inputs();
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            clear_inputs();
            for (int k = 0; k < NS; k++)
                set_ch(k, 2'($urandom), RA'($urandom_range(0, 7)), RA'($urandom_range(0, 7)), $urandom, $urandom,
                       1'($urandom), RA'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 3) == 0), $urandom);
            bus.src_hit   = NS'($urandom);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            step();
            n_cmp++; if (s_rdy !== e_rdy) begin n_fail++; $display("FAIL rnd_in_ready c%0d: got %b expected %b", c, s_rdy, e_rdy); end
            n_cmp++; if ({s_en1, s_en2} !== {e_en1, e_en2}) begin n_fail++; $display("FAIL rnd_rd_en c%0d: got %b%b expected %b%b", c, s_en1, s_en2, e_en1, e_en2); end
            n_cmp++; if ({s_a1, s_a2} !== {e_a1, e_a2}) begin n_fail++; $display("FAIL rnd_rd_addr c%0d: got %0d/%0d expected %0d/%0d", c, s_a1, s_a2, e_a1, e_a2); end
            n_cmp++; if (bus.out_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_out_valid c%0d: got %b expected %b", c, bus.out_valid, (mq.size() > 0)); end
            n_cmp++; if (bus.operand_1 !== e_head.op1) begin n_fail++; $display("FAIL rnd_operand_1 c%0d: got %h expected %h", c, bus.operand_1, e_head.op1); end
            n_cmp++; if (bus.operand_2 !== e_head.op2) begin n_fail++; $display("FAIL rnd_operand_2 c%0d: got %h expected %h", c, bus.operand_2, e_head.op2); end
            n_cmp++; if ({bus.write_reg_en, bus.write_reg_addr} !== {e_head.wen, e_head.waddr}) begin
                n_fail++; $display("FAIL rnd_write_reg c%0d: got %b/%0d expected %b/%0d", c, bus.write_reg_en, bus.write_reg_addr, e_head.wen, e_head.waddr); end
            n_cmp++; if ({o_br, o_bra} !== {m_br, m_bra}) begin n_fail++; $display("FAIL rnd_branch c%0d: got %b/%h expected %b/%h", c, o_br, o_bra, m_br, m_bra); end
            n_cmp++; if ({o_ill, o_multi} !== {m_ill, m_multi}) begin n_fail++; $display("FAIL rnd_flags c%0d: got %b%b expected %b%b", c, o_ill, o_multi, m_ill, m_multi); end
            n_cmp++; if (o_stall !== m_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %0d expected %0d", c, o_stall, m_stall); end
        end
    endtask

    task automatic test_reset_mid();
        drain();
        bus.out_ready = 1'b0;
        set_ch(0, 2'b00, 5'd0, 5'd0, 32'h77, 32'h0, 1'b1, 5'd3, 1'b1, 1'b0, '0);
        bus.in_valid = 1'b1;
        step();
        clear_inputs();
        set_ch(1, 2'b00, 5'd0, 5'd0, 32'h88, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h00001234);
        bus.in_valid = 1'b1;
        step();
        n_cmp++; if (o_br !== 1'b1 || bus.out_valid !== 1'b1 || o_stall !== m_stall) begin
            n_fail++; $display("FAIL rstm_setup: got br=%b v=%b stall=%0d expected 1/1/%0d", o_br, bus.out_valid, o_stall, m_stall); end
        clear_inputs();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstm_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (o_stall !== 16'd0) begin n_fail++; $display("FAIL rstm_stall: got %0d expected 0", o_stall); end
        n_cmp++; if ({o_br, o_bra, o_multi} !== '0) begin n_fail++; $display("FAIL rstm_branch_multi: got %b/%h/%b expected 0/0/0", o_br, o_bra, o_multi); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0 || o_br !== 1'b0) begin n_fail++; $display("FAIL rstm_after: got v=%b br=%b expected 0/0", bus.out_valid, o_br); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_illegal();
        test_load_use();
        test_zero_load();
        test_backpressure();
        test_branch();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
